// File: rtl/adder_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding and default width.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow-out. Purely combinational.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin in WIDTH shift cycles after acceptance.
// Operands accepted only in IDLE; the result is held in DONE until diff_ready.
module serial_subtractor
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             diff_valid,
  input  logic             diff_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             cell_d, cell_bout;

  full_subtractor u_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The minuend register doubles as the result register: each
        // difference bit fills the MSB vacated by the right shift.
        a_sh_d = {cell_d, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        br_d   = cell_bout;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d  = a_sh_d;
          bout_d  = cell_bout;
          ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
          state_d = DONE;
        end
      end
      DONE: begin
        if (diff_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign diff_valid  = (state_q == DONE);
  assign diff        = diff_q;
  assign bout        = bout_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         diff_valid;
  logic         diff_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;

  int n_vec = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .diff_valid  (diff_valid),
    .diff_ready  (diff_ready),
    .diff        (diff),
    .bout        (bout),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, unsigned for borrow, signed for overflow.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] md, output logic mbo, output logic movf);
    int u;
    int s;
    u    = int'(ma) - int'(mb) - int'(mbin);
    s    = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    md   = u[W-1:0];
    mbo  = (u < 0);
    movf = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
  endfunction

  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                       input int hold, input string tag);
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    int           lat;
    model(oa, ob, obin, ed, eb, eo);
    @(negedge clk);
    lat = 0;
    while (!start_ready && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ":start_ready"}, 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    a = oa;
    b = ob;
    bin = obin;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a = 'x;
    b = 'x;
    bin = 1'bx;
    lat = 0;
    while (!diff_valid && lat < 64) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check({tag, ":latency"}, 32'(lat), 32'(W));
    @(negedge clk);
    check({tag, ":diff"}, 32'(diff), 32'(ed));
    check({tag, ":bout"}, 32'(bout), 32'(eb));
    check({tag, ":overflow"}, 32'(overflow), 32'(eo));
    check({tag, ":busy"}, 32'(start_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      check({tag, ":hold_valid"}, 32'(diff_valid), 32'd1);
      check({tag, ":hold_diff"}, 32'(diff), 32'(ed));
      check({tag, ":hold_ready"}, 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    diff_ready = 1'b1;
    @(negedge clk);
    diff_ready = 1'b0;
    check({tag, ":release_valid"}, 32'(diff_valid), 32'd0);
    check({tag, ":release_ready"}, 32'(start_ready), 32'd1);
    check({tag, ":kept_diff"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    int           lat;
    int           seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_valid", 32'(diff_valid), 32'd0);
    check("rst_ready", 32'(start_ready), 32'd1);
    rst_n = 1'b1;

    // Directed vectors
    do_op(8'h37, 8'h15, 1'b0, 0, "d37m15");
    do_op(8'h15, 8'h37, 1'b0, 1, "d15m37");
    do_op(8'h80, 8'h01, 1'b0, 0, "d80m01");
    do_op(8'h00, 8'h00, 1'b1, 0, "d00m00b");
    do_op(8'h5C, 8'h5C, 1'b0, 0, "equal");
    do_op(8'h7F, 8'h80, 1'b1, 5, "backpressure");

    // start_valid held high: a new operand set only on the IDLE edge
    model(8'h5A, 8'hA5, 1'b0, ed, eb, eo);
    @(negedge clk);
    a = 8'h5A;
    b = 8'hA5;
    bin = 1'b0;
    start_valid = 1'b1;
    diff_ready = 1'b1;
    lat = 0;
    while (!diff_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("held_diff1", 32'(diff), 32'(ed));
    @(negedge clk);
    lat = 1;
    while (!diff_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("held_interval", 32'(lat), 32'(W + 2));
    check("held_diff2", 32'(diff), 32'(ed));
    check("held_bout", 32'(bout), 32'(eb));
    check("held_ovf", 32'(overflow), 32'(eo));
    start_valid = 1'b0;
    @(negedge clk);
    diff_ready = 1'b0;

    // Reset in the middle of SHIFT
    @(negedge clk);
    start_valid = 1'b1;
    a = 8'hF0;
    b = 8'h0F;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_valid", 32'(diff_valid), 32'd0);
    check("midrst_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (diff_valid) seen = 1;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);
    do_op(8'h01, 8'h01, 1'b0, 0, "after_rst");

    // Randomized operands and back-pressure
    for (int k = 0; k < 24; k++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
